// File: rtl/pipelined_controller.sv
// pipelined_controller: ID-stage decode, ID/EX control register, load-use and multiply stall control
module pipelined_controller #(
    parameter int ALUCTL_W    = 5,
    parameter int MULT_CYCLES = 4,
    parameter bit HAZARD_EN   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    input  logic [31:0]         instruction,
    input  logic                branch_taken,
    output logic                stall,
    output logic                flush,
    output logic                mult_busy,
    output logic                ex_valid,
    output logic                reg_write,
    output logic                alu_src,
    output logic                reg_dst,
    output logic                mem_write,
    output logic                mem_read,
    output logic                branch,
    output logic                mem_to_reg,
    output logic                jump,
    output logic                jr,
    output logic                jal,
    output logic [1:0]          mem_size,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic [4:0]          ex_dest_reg,
    output logic                illegal_instr
);
    localparam int CW = $clog2(MULT_CYCLES + 1);
    typedef enum logic {RUN, MUL_BUSY} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd, r_alu, d_alu, d_dest;
    logic [1:0] d_size;
    logic d_ok, d_rw, d_src, d_dst, d_mw, d_mr, d_br, d_m2r, d_j, d_jr, d_jal, d_mult;
    logic uses_rt, hazard, load_hazard, busy, issue, illegal, unused_shamt;
    assign op = instruction[31:26];
    assign rs = instruction[25:21];
    assign rt = instruction[20:16];
    assign rd = instruction[15:11];
    assign funct = instruction[5:0];
    assign unused_shamt = ^instruction[10:6];
    // R-type ALU code by funct; zero marks a funct that is not an ALU operation
    always_comb begin
        r_alu = 5'b00000;
        case (funct)
            6'h20: r_alu = 5'b00001;
            6'h22: r_alu = 5'b00010;
            6'h18: r_alu = 5'b00011;
            6'h00: r_alu = 5'b00100;
            6'h02: r_alu = 5'b00101;
            6'h24: r_alu = 5'b00110;
            6'h25: r_alu = 5'b00111;
            6'h26: r_alu = 5'b01000;
            6'h27: r_alu = 5'b01101;
            6'h2A: r_alu = 5'b01110;
            default: r_alu = 5'b00000;
        endcase
    end
    // Instruction decode; anything unrecognised leaves d_ok low and all controls zero
    always_comb begin
        {d_ok, d_rw, d_src, d_dst, d_mw, d_mr, d_br, d_m2r, d_j, d_jr, d_jal} = '0;
        d_size = 2'b00;
        d_alu = 5'b00000;
        d_dest = 5'd0;
        case (op)
            6'h00: begin
                if (funct == 6'h08) begin
                    d_ok = 1'b1;
                    d_jr = 1'b1;
                end else if (r_alu != 5'b00000) begin
                    {d_ok, d_rw, d_dst, d_m2r} = 4'b1111;
                    d_alu = r_alu;
                    d_dest = rd;
                end
            end
            6'h23, 6'h21, 6'h20: begin
                {d_ok, d_rw, d_src, d_mr} = 4'b1111;
                d_alu = 5'b00001;
                d_size = op[1] ? 2'b10 : {1'b0, op[0]};
                d_dest = rt;
            end
            6'h2B, 6'h29, 6'h28: begin
                {d_ok, d_src, d_mw} = 3'b111;
                d_alu = 5'b00001;
                d_size = op[1] ? 2'b10 : {1'b0, op[0]};
            end
            6'h0C, 6'h0D, 6'h0E, 6'h0A: begin
                {d_ok, d_rw, d_src, d_m2r} = 4'b1111;
                d_alu = (op == 6'h0C) ? 5'b00110 : (op == 6'h0D) ? 5'b00111 : (op == 6'h0E) ? 5'b01000 : 5'b01110;
                d_dest = rt;
            end
            6'h04, 6'h05, 6'h07, 6'h06: begin
                {d_ok, d_br} = 2'b11;
                d_alu = (op == 6'h04) ? 5'b01100 : (op == 6'h05) ? 5'b01111 : (op == 6'h07) ? 5'b10000 : 5'b10001;
            end
            6'h01: begin
                d_ok = (rt == 5'd0) || (rt == 5'd1);
                d_br = d_ok;
                d_alu = (rt == 5'd1) ? 5'b01111 : (rt == 5'd0) ? 5'b01100 : 5'b00000;
            end
            6'h02: {d_ok, d_j} = 2'b11;
            6'h03: begin
                {d_ok, d_j, d_jal, d_rw} = 4'b1111;
                d_dest = 5'd31;
            end
            default: d_ok = 1'b0;
        endcase
    end
    assign d_mult = (op == 6'h00) && (funct == 6'h18);
    assign uses_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h29) || (op == 6'h28) || (op == 6'h04) || (op == 6'h05);
    assign hazard = HAZARD_EN && ex_valid && mem_read && (ex_dest_reg != 5'd0) && ((ex_dest_reg == rs) || (uses_rt && (ex_dest_reg == rt)));
    assign busy = (state == MUL_BUSY);
    assign mult_busy = busy;
    assign flush = branch_taken && !busy;
    assign load_hazard = hazard && instr_valid && !flush;
    assign stall = busy || load_hazard;
    assign issue = !busy && !flush && !load_hazard && instr_valid && d_ok;
    assign illegal = !busy && !flush && !load_hazard && instr_valid && !d_ok;
    // Multiply occupancy state and countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
        end
    end
    // Enter MUL_BUSY when a mult issues; leave once the countdown reaches one
    always_comb begin
        state_nxt = state;
        cnt_nxt = cnt;
        if (busy) begin
            cnt_nxt = cnt - CW'(1);
            state_nxt = (cnt == CW'(1)) ? RUN : MUL_BUSY;
        end else if (issue && d_mult && (MULT_CYCLES > 1)) begin
            state_nxt = MUL_BUSY;
            cnt_nxt = CW'(MULT_CYCLES - 1);
        end
    end
    // ID/EX control register: held during multiply, otherwise decoded bundle or bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {ex_valid, reg_write, alu_src, reg_dst, mem_write, mem_read, branch, mem_to_reg, jump, jr, jal} <= '0;
            mem_size <= 2'b00;
            alu_control <= '0;
            ex_dest_reg <= 5'd0;
            illegal_instr <= 1'b0;
        end else begin
            illegal_instr <= illegal;
            if (!busy) begin
                ex_valid <= issue;
                reg_write <= issue && d_rw;
                alu_src <= issue && d_src;
                reg_dst <= issue && d_dst;
                mem_write <= issue && d_mw;
                mem_read <= issue && d_mr;
                branch <= issue && d_br;
                mem_to_reg <= issue && d_m2r;
                jump <= issue && d_j;
                jr <= issue && d_jr;
                jal <= issue && d_jal;
                mem_size <= issue ? d_size : 2'b00;
                alu_control <= issue ? ALUCTL_W'(d_alu) : '0;
                ex_dest_reg <= issue ? d_dest : 5'd0;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_controller.sv
// tb_pipelined_controller: scoreboard bench with a behavioural model of the decode-stage controller
module tb_pipelined_controller;
    localparam int MC = 4;
    localparam bit HZ = 1'b1;
    typedef struct packed {
        logic v, rw, src, dst, mw, mr, br, m2r, j, jr, jal;
        logic [1:0] sz;
        logic [4:0] alu, dest;
        logic ill;
    } bundle_t;
    logic clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0, branch_taken = 1'b0;
    logic [31:0] instruction = 32'd0;
    logic stall, flush, mult_busy, ex_valid, reg_write, alu_src, reg_dst, mem_write, mem_read;
    logic branch, mem_to_reg, jump, jr, jal, illegal_instr;
    logic [1:0] mem_size;
    logic [4:0] alu_control, ex_dest_reg;
    bundle_t act;
    bundle_t q[$];
    int n_checks = 0, n_fail = 0;
    int busy_left = 0;
    logic [4:0] ld_dest = 5'd0;
    bundle_t held = '0;
    logic m_stall = 1'b0;
    logic [5:0] ops [0:22] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h21, 6'h20, 6'h2B, 6'h29, 6'h28, 6'h0C, 6'h0D,
                                6'h0E, 6'h0A, 6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h02, 6'h03, 6'h3F, 6'h22};
    logic [5:0] fns [0:11] = '{6'h20, 6'h22, 6'h18, 6'h00, 6'h02, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h08, 6'h01};
    int rfn [0:9] = '{'h20, 'h22, 'h18, 'h00, 'h02, 'h24, 'h25, 'h26, 'h27, 'h2A};
    int rcode [0:9] = '{1, 2, 3, 4, 5, 6, 7, 8, 13, 14};

    always #5 clk = ~clk;

    pipelined_controller #(.ALUCTL_W(5), .MULT_CYCLES(MC), .HAZARD_EN(HZ)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instruction(instruction),
        .branch_taken(branch_taken), .stall(stall), .flush(flush), .mult_busy(mult_busy),
        .ex_valid(ex_valid), .reg_write(reg_write), .alu_src(alu_src), .reg_dst(reg_dst),
        .mem_write(mem_write), .mem_read(mem_read), .branch(branch), .mem_to_reg(mem_to_reg),
        .jump(jump), .jr(jr), .jal(jal), .mem_size(mem_size), .alu_control(alu_control),
        .ex_dest_reg(ex_dest_reg), .illegal_instr(illegal_instr)
    );

    assign act = {ex_valid, reg_write, alu_src, reg_dst, mem_write, mem_read, branch, mem_to_reg,
                  jump, jr, jal, mem_size, alu_control, ex_dest_reg, illegal_instr};

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
        end
    endtask

    // Expected ID/EX bundle for one instruction, from the instruction-set table
    function automatic bundle_t dec(input logic [31:0] i);
        bundle_t b;
        logic [5:0] op, fn;
        logic [4:0] rt;
        logic bad;
        b = '0;
        bad = 1'b0;
        op = i[31:26];
        fn = i[5:0];
        rt = i[20:16];
        b.v = 1'b1;
        case (op)
            6'h00: begin
                if (fn == 6'h08) b.jr = 1'b1;
                else begin
                    bad = 1'b1;
                    for (int k = 0; k < 10; k++)
                        if (rfn[k] == int'(fn)) begin
                            bad = 1'b0;
                            b.alu = 5'(rcode[k]);
                        end
                    b.rw = 1'b1; b.dst = 1'b1; b.m2r = 1'b1; b.dest = i[15:11];
                end
            end
            6'h23, 6'h21, 6'h20: begin
                b.rw = 1'b1; b.src = 1'b1; b.mr = 1'b1; b.alu = 5'd1; b.dest = rt;
                b.sz = (op == 6'h23) ? 2'd2 : (op == 6'h21) ? 2'd1 : 2'd0;
            end
            6'h2B, 6'h29, 6'h28: begin
                b.src = 1'b1; b.mw = 1'b1; b.alu = 5'd1;
                b.sz = (op == 6'h2B) ? 2'd2 : (op == 6'h29) ? 2'd1 : 2'd0;
            end
            6'h0C: begin b.rw = 1'b1; b.src = 1'b1; b.m2r = 1'b1; b.dest = rt; b.alu = 5'd6; end
            6'h0D: begin b.rw = 1'b1; b.src = 1'b1; b.m2r = 1'b1; b.dest = rt; b.alu = 5'd7; end
            6'h0E: begin b.rw = 1'b1; b.src = 1'b1; b.m2r = 1'b1; b.dest = rt; b.alu = 5'd8; end
            6'h0A: begin b.rw = 1'b1; b.src = 1'b1; b.m2r = 1'b1; b.dest = rt; b.alu = 5'd14; end
            6'h04: begin b.br = 1'b1; b.alu = 5'd12; end
            6'h05: begin b.br = 1'b1; b.alu = 5'd15; end
            6'h07: begin b.br = 1'b1; b.alu = 5'd16; end
            6'h06: begin b.br = 1'b1; b.alu = 5'd17; end
            6'h01: begin
                b.br = 1'b1;
                if (rt == 5'd1) b.alu = 5'd15;
                else if (rt == 5'd0) b.alu = 5'd12;
                else bad = 1'b1;
            end
            6'h02: b.j = 1'b1;
            6'h03: begin b.j = 1'b1; b.jal = 1'b1; b.rw = 1'b1; b.dest = 5'd31; end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            b = '0;
            b.ill = 1'b1;
        end
        return b;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        op = ops[$urandom_range(0, 22)];
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        if (op == 6'h00) return {op, rs, rt, rd, 5'd0, fns[$urandom_range(0, 11)]};
        return {op, rs, rt, 16'($urandom)};
    endfunction

    // One cycle: drive, check combinational outputs, predict the next ID/EX bundle
    task automatic step(input logic iv, input logic [31:0] ins, input logic bt);
        bundle_t nxt;
        logic [5:0] op;
        logic [4:0] rs, rt;
        logic busy, haz, fl, urt;
        @(negedge clk);
        instr_valid = iv;
        instruction = ins;
        branch_taken = bt;
        #1;
        op = ins[31:26];
        rs = ins[25:21];
        rt = ins[20:16];
        busy = busy_left > 0;
        urt = op inside {6'h00, 6'h2B, 6'h29, 6'h28, 6'h04, 6'h05};
        haz = HZ && iv && (ld_dest != 5'd0) && ((ld_dest == rs) || (urt && (ld_dest == rt)));
        fl = bt && !busy;
        m_stall = busy || (haz && !fl);
        chk("stall", 32'(stall), 32'(m_stall));
        chk("flush", 32'(flush), 32'(fl));
        chk("mult_busy", 32'(mult_busy), 32'(busy));
        nxt = '0;
        if (busy) begin
            nxt = held;
            busy_left--;
        end else if (!fl && !haz && iv) begin
            nxt = dec(ins);
            if (nxt.v && (op == 6'h00) && (ins[5:0] == 6'h18)) busy_left = MC - 1;
        end
        held = nxt;
        held.ill = 1'b0;
        ld_dest = (nxt.v && nxt.mr) ? nxt.dest : 5'd0;
        q.push_back(nxt);
    endtask

    // Present an instruction and keep it in IF/ID while the controller stalls
    task automatic issue(input logic iv, input logic [31:0] ins, input logic bt);
        step(iv, ins, bt);
        for (int k = 0; k < MC + 2 && m_stall; k++) step(iv, ins, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) chk("idex_bundle", 32'(act), 32'(q.pop_front()));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #1;
        chk("reset_bundle", 32'(act), 32'd0);
        chk("reset_mult_busy", 32'(mult_busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b1, 32'h8C080000, 1'b0);
        issue(1'b1, 32'h010A4820, 1'b0);
        issue(1'b1, 32'h01090018, 1'b0);
        issue(1'b1, 32'h012A5822, 1'b0);
        issue(1'b1, 32'h8C080000, 1'b0);
        issue(1'b1, 32'h010A4820, 1'b1);
        issue(1'b1, 32'hFC000000, 1'b0);
        issue(1'b1, 32'h04020000, 1'b0);
        issue(1'b1, 32'h0C000010, 1'b0);
        issue(1'b1, 32'hA5090004, 1'b0);
        issue(1'b1, 32'h03E00008, 1'b0);
        step(1'b1, 32'h01090018, 1'b0);
        step(1'b1, 32'h010A4820, 1'b0);
        @(negedge clk);
        chk("mult_busy_before_reset", 32'(mult_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_bundle", 32'(act), 32'd0);
        chk("async_reset_mult_busy", 32'(mult_busy), 32'd0);
        chk("async_reset_stall", 32'(stall), 32'd0);
        q.delete();
        busy_left = 0;
        ld_dest = 5'd0;
        held = '0;
        m_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b1, 32'h010A4820, 1'b0);
        repeat (400) issue($urandom_range(0, 7) != 0, rnd_instr(), $urandom_range(0, 9) == 0);
        for (int k = 0; k < MC + 1; k++) step(1'b0, 32'd0, 1'b0);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
